// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider handshake bundle.
//   master: pipeline side (drives start/operands/hold/flush, sees stall/valid/result)
//   slave : divider side
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 hold_i;
  logic                 flush_i;
  logic                 stall_o;
  logic                 valid_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, a_i, b_i, hold_i, flush_i,
    input  stall_o, valid_o, result_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, hold_i, flush_i,
    output stall_o, valid_o, result_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring radix-2 divider with sequencing FSM for DIV/DIVU.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus.slave  start_i/signed_i/a_i/b_i/hold_i/flush_i in,
//              stall_o (combinational), valid_o, result_o = {remainder, quotient} out
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   r_iter, q_iter;

  // Operand magnitudes and one restoring iteration
  always_comb begin
    a_mag     = (bus.signed_i & bus.a_i[WIDTH-1]) ? WIDTH'('0 - bus.a_i) : bus.a_i;
    b_mag     = (bus.signed_i & bus.b_i[WIDTH-1]) ? WIDTH'('0 - bus.b_i) : bus.b_i;
    rem_shift = {r_q, q_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, b_q});
    r_iter    = rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
    q_iter    = {q_q[WIDTH-2:0], rem_ge};
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.b_i != '0) begin
            state_d = BUSY;
            r_d     = '0;
            q_d     = a_mag;
            b_d     = b_mag;
            cnt_d   = CNT_W'(WIDTH);
            q_neg_d = bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            r_neg_d = bus.signed_i & bus.a_i[WIDTH-1];
          end else begin
            // Divide by zero: skip iterations, return dividend and all-ones
            state_d  = DONE;
            result_d = {bus.a_i, {WIDTH{1'b1}}};
          end
        end
      end
      BUSY: begin
        r_d   = r_iter;
        q_d   = q_iter;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = {r_neg_q ? WIDTH'('0 - r_iter) : r_iter,
                      q_neg_q ? WIDTH'('0 - q_iter) : q_iter};
        end
      end
      DONE: begin
        if (!bus.hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush_i) state_d = IDLE;

    valid_d = (state_d == DONE);
    // Result is only presented while in DONE; anything else is discarded
    if (state_d != DONE) result_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Stall is combinational so the start cycle itself holds Execute; gated off in reset
  assign bus.stall_o  = rst & ~bus.flush_i &
                        (((state_q == IDLE) & bus.start_i) | (state_q == BUSY));
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule
